// File: rtl/riscv_pkg.sv
// Shared core constants and types used by the fetch queue.
// IFQ_FAULT_EN adds a per-entry instruction-fault bit to ifq_entry_t.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = '0;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
`ifdef IFQ_FAULT_EN
    logic            fault;
`endif
  } ifq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear. Simultaneous push/pop on a full FIFO is accepted.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push && !(rst || clear)) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch queue between the PC register and decode: credit-limited imem requests,
// in-order response buffering, flush-time drop of wrong-path responses. Option: IFQ_FAULT_EN.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  output logic            FetchStallF,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
`ifdef IFQ_FAULT_EN
  input  logic            imem_rsp_err,
  output logic            InstrFaultD,
`endif
  input  logic            StallD,
  input  logic            FlushD,
  output logic            ValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $bits(ifq_entry_t);

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_sum;
  logic            fire;
  logic            rsp_keep;
  logic            empty;
  logic            deq;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   head_bits;
  ifq_entry_t      rsp_entry;
  ifq_entry_t      head;

  logic            unused_tag_full;
  logic            unused_tag_empty;
  logic [CW-1:0]   unused_tag_count;
  logic            unused_instr_full;

  // Outstanding requests (dropped ones included) plus buffered entries never exceed DEPTH.
  assign credit_sum     = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = ~FlushD & ~rst & (credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = PCF;
  assign fire           = imem_req_valid & imem_req_ready;
  assign FetchStallF    = ~fire;

  assign rsp_keep = imem_rsp_valid & ~FlushD & (drop == '0);
  assign ValidD   = ~empty;
  assign deq      = ValidD & ~StallD & ~FlushD;

  always_comb begin
    rsp_entry       = '0;
    rsp_entry.pc    = tag_pc;
    rsp_entry.instr = imem_rsp_data;
`ifdef IFQ_FAULT_EN
    rsp_entry.fault = imem_rsp_err;
`endif
  end

  assign head     = ifq_entry_t'(head_bits);
  assign InstrD   = ValidD ? head.instr : NOP_INSTR;
  assign PCD      = ValidD ? head.pc : RESET_PC;
  assign PCPlus4D = PCD + XLEN'(4);
`ifdef IFQ_FAULT_EN
  assign InstrFaultD = ValidD & head.fault;
`endif

  // Every response retires one outstanding request, whether kept or dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
      if (FlushD)
        drop <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0)
        drop <= drop - CW'(1);
    end
  end

  // Tags are never cleared on flush: dropped responses still consume them.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (fire),
    .pop   (imem_rsp_valid),
    .din   (PCF),
    .dout  (tag_pc),
    .full  (unused_tag_full),
    .empty (unused_tag_empty),
    .count (unused_tag_count)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (FlushD),
    .push  (rsp_keep),
    .pop   (deq),
    .din   (rsp_entry),
    .dout  (head_bits),
    .full  (unused_instr_full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fetch latency, back-pressure, credit limit,
// flush drop, pop/push overlap, and (with IFQ_FAULT_EN) fault propagation.
module tb_ifetch_queue;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] PCF;
  logic            FetchStallF;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
`ifdef IFQ_FAULT_EN
  logic            imem_rsp_err;
  logic            InstrFaultD;
`endif
  logic            StallD;
  logic            FlushD;
  logic            ValidD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  ifetch_queue #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCF            (PCF),
    .FetchStallF    (FetchStallF),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
`ifdef IFQ_FAULT_EN
    .imem_rsp_err   (imem_rsp_err),
    .InstrFaultD    (InstrFaultD),
`endif
    .StallD         (StallD),
    .FlushD         (FlushD),
    .ValidD         (ValidD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; PCF = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; StallD = 1'b0; FlushD = 1'b0;
`ifdef IFQ_FAULT_EN
    imem_rsp_err = 1'b0;
`endif
    tick(); tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_validd", ValidD, 0);
    check("rst_instrd", InstrD, 32'h0000_0013);
    check("rst_pcd", PCD, 0);
    check("rst_pcplus4", PCPlus4D, 4);
    rst = 1'b0;

    // single fetch: fire at t, response t+1, ValidD at t+2
    StallD = 1'b1; PCF = 32'h0; imem_req_ready = 1'b1; settle();
    check("sf_req_valid", imem_req_valid, 1);
    check("sf_stall", FetchStallF, 0);
    check("sf_addr", imem_req_addr, 0);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093; settle();
    check("sf_no_bypass", ValidD, 0);
    tick();
    imem_rsp_valid = 1'b0; settle();
    check("sf_validd", ValidD, 1);
    check("sf_instrd", InstrD, 32'h0050_0093);
    check("sf_pcd", PCD, 0);
    check("sf_pcplus4", PCPlus4D, 4);
    StallD = 1'b0; tick();
    check("sf_popped", ValidD, 0);
    check("sf_nop", InstrD, 32'h0000_0013);

    // back-pressure at 0x10
    PCF = 32'h10; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_stall", FetchStallF, 1);
      check("bp_req_valid", imem_req_valid, 1);
      tick();
    end
    imem_req_ready = 1'b1; settle();
    check("bp_fire", FetchStallF, 0);
    check("bp_addr", imem_req_addr, 32'h10);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0513; tick();
    imem_rsp_valid = 1'b0; settle();
    check("bp_validd", ValidD, 1);
    check("bp_pcd", PCD, 32'h10);
    tick();
    check("bp_single_fire", ValidD, 0);

    // credit limit with decode stalled
    StallD = 1'b1; imem_req_ready = 1'b1; PCF = 32'h0; settle();
    check("cr_rv0", imem_req_valid, 1);
    tick();
    PCF = 32'h4; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093; settle();
    check("cr_rv1", imem_req_valid, 1);
    check("cr_addr1", imem_req_addr, 32'h4);
    tick();
    PCF = 32'h8; imem_rsp_data = 32'h0020_0113; settle();
    check("cr_rv2", imem_req_valid, 0);
    check("cr_stall2", FetchStallF, 1);
    tick();
    imem_rsp_valid = 1'b0; settle();
    check("cr_rv3", imem_req_valid, 0);
    check("cr_head_instr", InstrD, 32'h0010_0093);
    check("cr_head_pc", PCD, 0);
    tick();
    check("cr_rv4", imem_req_valid, 0);

    // drain one, refill, then pop and push in the same cycle
    exp_q.push_back(32'h0020_0113);
    exp_q.push_back(32'h0030_0193);
    StallD = 1'b0; settle();
    check("pp_rv_full", imem_req_valid, 0);
    tick();
    StallD = 1'b1; settle();
    check("pp_rv_after_pop", imem_req_valid, 1);
    check("pp_addr", imem_req_addr, 32'h8);
    check("pp_pc_i1", PCD, 32'h4);
    tick();
    imem_req_ready = 1'b0; StallD = 1'b0; imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0030_0193; settle();
    check("pp_rv_busy", imem_req_valid, 0);
    check("pp_order_i1", InstrD, exp_q.pop_front());
    tick();
    imem_rsp_valid = 1'b0; StallD = 1'b1; settle();
    check("pp_valid", ValidD, 1);
    check("pp_order_i2", InstrD, exp_q.pop_front());
    check("pp_pc_i2", PCD, 32'h8);
    check("pp_credit_one", imem_req_valid, 1);
    StallD = 1'b0; tick();
    check("pp_drained", ValidD, 0);

    // flush with two outstanding requests
    StallD = 1'b1; imem_req_ready = 1'b1; PCF = 32'h20; tick();
    PCF = 32'h24; tick();
    FlushD = 1'b1; PCF = 32'h100; settle();
    check("fl_rv_flush", imem_req_valid, 0);
    check("fl_stall_flush", FetchStallF, 1);
    tick();
    FlushD = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0001; settle();
    check("fl_rv_credit", imem_req_valid, 0);
    tick();
    imem_rsp_data = 32'hDEAD_0002; settle();
    check("fl_drop1", ValidD, 0);
    check("fl_rv_target", imem_req_valid, 1);
    check("fl_addr_target", imem_req_addr, 32'h100);
    tick();
    imem_req_ready = 1'b0; imem_rsp_data = 32'h0030_0193; settle();
    check("fl_drop2", ValidD, 0);
    tick();
    imem_rsp_valid = 1'b0; settle();
    check("fl_validd", ValidD, 1);
    check("fl_pcd", PCD, 32'h100);
    check("fl_instrd", InstrD, 32'h0030_0193);
    StallD = 1'b0; tick();

    // response arriving in the flush cycle is discarded and credit recovers
    StallD = 1'b1; imem_req_ready = 1'b1; PCF = 32'h8; tick();
    imem_req_ready = 1'b0; FlushD = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0008;
`ifdef IFQ_FAULT_EN
    imem_rsp_err = 1'b1;
`endif
    settle();
`ifdef IFQ_FAULT_EN
    check("ff_fault_flush", InstrFaultD, 0);
`endif
    tick();
    FlushD = 1'b0; imem_rsp_valid = 1'b0;
`ifdef IFQ_FAULT_EN
    imem_rsp_err = 1'b0;
`endif
    settle();
    check("ff_validd", ValidD, 0);
    check("ff_credit", imem_req_valid, 1);
`ifdef IFQ_FAULT_EN
    check("ff_fault_after", InstrFaultD, 0);
`endif
    imem_req_ready = 1'b1; PCF = 32'h40; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0213; tick();
    imem_rsp_valid = 1'b0; settle();
    check("ff_next_valid", ValidD, 1);
    check("ff_next_pc", PCD, 32'h40);
    check("ff_next_instr", InstrD, 32'h0040_0213);
    StallD = 1'b0; tick();

`ifdef IFQ_FAULT_EN
    // faulting fetch at 0x8 raises InstrFaultD only while it is head
    StallD = 1'b1; imem_req_ready = 1'b1; PCF = 32'h8; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1;
    imem_rsp_data = 32'h0000_0073; settle();
    check("ft_not_yet", InstrFaultD, 0);
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; settle();
    check("ft_fault", InstrFaultD, 1);
    check("ft_pc", PCD, 32'h8);
    tick();
    check("ft_fault_held", InstrFaultD, 1);
    StallD = 1'b0; tick();
    check("ft_fault_gone", InstrFaultD, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
